// File: rtl/bram_resp_pkg.sv
// bram_resp_pkg: shared widths and dump-engine state encoding for bram_resp_dump.
package bram_resp_pkg;
    localparam int WORD_W = 32;
    localparam int WE_W   = 4;
    typedef enum logic [1:0] {IDLE, FETCH, HOLD} dump_state_t;
endpackage

// File: rtl/bram_dp_mem.sv
// bram_dp_mem: dual-port word memory, byte-enabled write on port A, read-only port B, registered read-first outputs.
module bram_dp_mem
    import bram_resp_pkg::*;
#(
    parameter int AW = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_en,
    input  logic              a_rst,
    input  logic [WE_W-1:0]   a_we,
    input  logic [AW-1:0]     a_addr,
    input  logic [WORD_W-1:0] a_wdata,
    output logic [WORD_W-1:0] a_rdata,
    input  logic              b_en,
    input  logic [AW-1:0]     b_addr,
    output logic [WORD_W-1:0] b_rdata
);
    logic [WORD_W-1:0] mem [2**AW];

    // Array kept out of the reset domain so it still maps onto block RAM.
    always_ff @(posedge clk)
        if (a_en)
            for (int i = 0; i < WE_W; i++)
                if (a_we[i]) mem[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            a_rdata <= '0;
            b_rdata <= '0;
        end else begin
            if (a_en) a_rdata <= a_rst ? '0 : mem[a_addr];
            if (b_en) b_rdata <= mem[b_addr];
        end
endmodule

// File: rtl/bram_resp_dump.sv
// bram_resp_dump: BRAM responder for the PE-array master that streams a result window after done rises.
module bram_resp_dump
    import bram_resp_pkg::*;
#(
    parameter int ADDR_WIDTH = 13,
    parameter int DUMP_BASE  = 0,
    parameter int DUMP_WORDS = 16
) (
    input  logic              S_AXI_ACLK,
    input  logic              S_AXI_ARESETN,
    input  logic [31:0]       BRAM_ADDR,
    input  logic [WORD_W-1:0] BRAM_WRDATA,
    input  logic [WE_W-1:0]   BRAM_WE,
    input  logic              BRAM_EN,
    input  logic              BRAM_RST,
    output logic [WORD_W-1:0] BRAM_RDDATA,
    input  logic              done,
    output logic [WORD_W-1:0] dump_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic              dump_last,
    output logic              dump_busy,
    output logic              dump_done
);
    localparam int AW = ADDR_WIDTH - 2;
    localparam logic [AW-1:0] BASE = AW'(DUMP_BASE);
    localparam logic [AW-1:0] LAST = AW'(DUMP_BASE + DUMP_WORDS - 1);

    dump_state_t state, state_nx;
    logic [AW-1:0] ptr;
    logic done_q, start, accept, unused_addr;

    assign unused_addr = ^{BRAM_ADDR[31:ADDR_WIDTH], BRAM_ADDR[1:0]};

    bram_dp_mem #(.AW(AW)) u_mem (
        .clk     (S_AXI_ACLK),
        .rst_n   (S_AXI_ARESETN),
        .a_en    (BRAM_EN),
        .a_rst   (BRAM_RST),
        .a_we    (BRAM_WE),
        .a_addr  (BRAM_ADDR[ADDR_WIDTH-1:2]),
        .a_wdata (BRAM_WRDATA),
        .a_rdata (BRAM_RDDATA),
        .b_en    (state == FETCH),
        .b_addr  (ptr),
        .b_rdata (dump_data)
    );

    always_comb begin
        start      = (state == IDLE) && done && !done_q;
        dump_valid = state == HOLD;
        dump_busy  = state != IDLE;
        dump_last  = dump_valid && (ptr == LAST);
        accept     = dump_valid && dump_ready;
        state_nx   = start ? FETCH :
                     (state == FETCH) ? HOLD :
                     accept ? (dump_last ? IDLE : FETCH) : state;
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
        if (!S_AXI_ARESETN) begin
            state     <= IDLE;
            ptr       <= BASE;
            done_q    <= 1'b0;
            dump_done <= 1'b0;
        end else begin
            state     <= state_nx;
            done_q    <= done;
            dump_done <= accept && dump_last;
            if (start) ptr <= BASE;
            else if (accept) ptr <= ptr + AW'(1);
        end
endmodule

// File: tb/tb_bram_resp_dump.sv
// tb_bram_resp_dump: table vectors for port A, randomized port A against a memory model, dump sequences.
module tb_bram_resp_dump;
    localparam int WORDS = 16;
    localparam int BASE  = 0;

    logic        clk = 0, rst_n = 0;
    logic [31:0] BRAM_ADDR = 0, BRAM_WRDATA = 0, BRAM_RDDATA, dump_data;
    logic [3:0]  BRAM_WE = 0;
    logic        BRAM_EN = 0, BRAM_RST = 0, done = 0, dump_ready = 0;
    logic        dump_valid, dump_last, dump_busy, dump_done;

    int vec = 0, errs = 0;
    logic [31:0] mdl [2048];
    logic [31:0] exp_rd;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  we;
        bit          en;
        bit          rst;
        bit          c;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [10];

    bram_resp_dump dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .BRAM_ADDR(BRAM_ADDR), .BRAM_WRDATA(BRAM_WRDATA), .BRAM_WE(BRAM_WE),
        .BRAM_EN(BRAM_EN), .BRAM_RST(BRAM_RST), .BRAM_RDDATA(BRAM_RDDATA),
        .done(done), .dump_data(dump_data), .dump_valid(dump_valid),
        .dump_ready(dump_ready), .dump_last(dump_last), .dump_busy(dump_busy),
        .dump_done(dump_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vec++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Inputs change at the negedge; outputs are examined on the next negedge.
    task automatic pa(input logic [31:0] a, wd, input logic [3:0] we, input bit en, rst);
        BRAM_ADDR = a; BRAM_WRDATA = wd; BRAM_WE = we; BRAM_EN = en; BRAM_RST = rst;
        @(negedge clk);
        BRAM_EN = 0; BRAM_WE = 0; BRAM_RST = 0;
    endtask

    task automatic model_op(input logic [31:0] a, wd, input logic [3:0] we, input bit en, rst);
        int w = int'(a[12:2]);
        if (en) begin
            exp_rd = rst ? 32'h0 : mdl[w];
            for (int i = 0; i < 4; i++)
                if (we[i]) mdl[w][8*i +: 8] = wd[8*i +: 8];
        end
    endtask

    task automatic run_dump(input bit rnd, input bit repulse, input int stop_at);
        int k = 0, cyc = 0;
        bit seen = 0, pv = 0, pr = 0, fin = 0, hs;
        logic [31:0] pd = 0;
        logic pl = 0;
        done = 0;
        @(negedge clk);
        done = 1;
        dump_ready = 1;
        while (!fin && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            hs = pv && pr;
            if (hs) k++;
            if (hs && k == WORDS) begin
                chk("dump_done_pulse", {31'b0, dump_done}, 1);
                chk("busy_at_done", {31'b0, dump_busy}, 0);
                chk("valid_at_done", {31'b0, dump_valid}, 0);
                fin = 1;
            end else begin
                chk("dump_done_low", {31'b0, dump_done}, 0);
                if (pv && !pr) begin
                    chk("valid_held", {31'b0, dump_valid}, 1);
                    chk("data_stable", dump_data, pd);
                    chk("last_stable", {31'b0, dump_last}, {31'b0, pl});
                end
                if (dump_valid) begin
                    if (!seen) begin
                        seen = 1;
                        chk("first_valid_cycle", cyc, 2);
                    end
                    chk("dump_data", dump_data, mdl[BASE + k]);
                    chk("dump_last", {31'b0, dump_last}, {31'b0, k == WORDS - 1});
                end
                pd = dump_data;
                pl = dump_last;
            end
            if (stop_at > 0 && k == stop_at) return;
            pv = dump_valid;
            dump_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            pr = dump_ready;
            if (repulse) done = !((cyc >= 4 && cyc < 10) || cyc >= 20);
        end
        if (!fin) chk("dump_timeout", 0, 1);
        @(negedge clk);
        chk("dump_done_one_cycle", {31'b0, dump_done}, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_retrigger", {31'b0, dump_busy}, 0);
        end
        done = 0;
        dump_ready = 0;
    endtask

    initial begin
        tbl[0] = '{32'h10, 32'hDEADBEEF, 4'hF, 1, 0, 0, 32'h0};
        tbl[1] = '{32'h10, 32'h12345678, 4'h3, 1, 0, 1, 32'hDEADBEEF};
        tbl[2] = '{32'h10, 32'h0,        4'h0, 1, 0, 1, 32'hDEAD5678};
        tbl[3] = '{32'h20, 32'h11111111, 4'hF, 1, 0, 0, 32'h0};
        tbl[4] = '{32'h20, 32'h22222222, 4'hF, 1, 0, 1, 32'h11111111};
        tbl[5] = '{32'h20, 32'h0,        4'h0, 1, 0, 1, 32'h22222222};
        tbl[6] = '{32'h20, 32'h33333333, 4'hF, 0, 0, 1, 32'h22222222};
        tbl[7] = '{32'h20, 32'h0,        4'h0, 1, 0, 1, 32'h22222222};
        tbl[8] = '{32'h20, 32'h44444444, 4'hF, 1, 1, 1, 32'h0};
        tbl[9] = '{32'h20, 32'h0,        4'h0, 1, 0, 1, 32'h44444444};

        #1;
        chk("rst_rddata", BRAM_RDDATA, 0);
        chk("rst_dump_data", dump_data, 0);
        chk("rst_flags", {28'b0, dump_valid, dump_last, dump_busy, dump_done}, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        foreach (tbl[i]) begin
            pa(tbl[i].addr, tbl[i].wd, tbl[i].we, tbl[i].en, tbl[i].rst);
            if (tbl[i].c) chk($sformatf("table_%0d", i), BRAM_RDDATA, tbl[i].exp);
        end

        for (int w = 0; w < 64; w++) begin
            logic [31:0] d = $urandom;
            model_op(32'(w << 2), d, 4'hF, 1, 0);
            pa(32'(w << 2), d, 4'hF, 1, 0);
        end
        for (int n = 0; n < 200; n++) begin
            logic [31:0] a, d;
            logic [3:0] we;
            bit en, rs;
            a  = {$urandom_range(0, 32'h7FFFF), 13'b0} | 32'($urandom_range(0, 63) << 2) | 32'($urandom_range(0, 3));
            d  = $urandom;
            we = 4'($urandom);
            en = n == 0 || $urandom_range(0, 3) != 0;
            rs = $urandom_range(0, 7) == 0;
            model_op(a, d, we, en, rs);
            pa(a, d, we, en, rs);
            if (!$isunknown(exp_rd)) chk("porta_random", BRAM_RDDATA, exp_rd);
        end

        for (int w = 0; w < WORDS; w++) begin
            model_op(32'((BASE + w) << 2), 32'(w * 3), 4'hF, 1, 0);
            pa(32'((BASE + w) << 2), 32'(w * 3), 4'hF, 1, 0);
        end

        run_dump(0, 0, 0);
        run_dump(1, 1, 0);

        run_dump(0, 0, 5);
        #2 rst_n = 0;
        #1;
        chk("midrst_flags", {28'b0, dump_valid, dump_last, dump_busy, dump_done}, 0);
        chk("midrst_data", dump_data, 0);
        chk("midrst_rddata", BRAM_RDDATA, 0);
        done = 0;
        @(negedge clk);
        chk("midrst_no_done", {31'b0, dump_done}, 0);
        rst_n = 1;
        @(negedge clk);
        chk("post_rst_idle", {31'b0, dump_busy}, 0);
        run_dump(1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
